// File: rtl/rotate_left_seq_pkg.sv
// Shared definitions for the sequential left-rotate block: default widths
// and FSM state encodings used by the RTL and its bench.
package rotate_left_seq_pkg;

  localparam int W_DEF     = 8;
  localparam int AMT_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/rotate_left_seq_if.sv
// Request/result bundle for rotate_left_seq: the master issues start/a/amt,
// the slave returns y/busy/done.
interface rotate_left_seq_if
  import rotate_left_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int AMT_W = AMT_W_DEF
);

  logic             start;
  logic [W-1:0]     a;
  logic [AMT_W-1:0] amt;
  logic [W-1:0]     y;
  logic             busy;
  logic             done;

  modport master (
    output start, a, amt,
    input  y, busy, done
  );

  modport slave (
    input  start, a, amt,
    output y, busy, done
  );

endinterface

// File: rtl/rotate_left_seq_test.sv
// Board wrapper: switches give the word, buttons give amount and a start
// press (edge-detected), LEDs show the result plus busy/done.
module rotate_left_seq_test
  import rotate_left_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_sw,
  input  logic [3:0] i_btn,
  output logic [9:0] o_led
);

  logic r_btn_start;
  logic w_start_pulse;

  rotate_left_seq_if #(.W(W_DEF), .AMT_W(AMT_W_DEF)) w_bus ();

  // A held button must only launch one operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_start <= 1'b0;
    end else begin
      r_btn_start <= i_btn[3];
    end
  end

  assign w_start_pulse = i_btn[3] & ~r_btn_start;

  assign w_bus.start = w_start_pulse;
  assign w_bus.a     = i_sw;
  assign w_bus.amt   = i_btn[2:0];

  rotate_left_seq #(.W(W_DEF), .AMT_W(AMT_W_DEF)) u_rot (
    .clk   (clk),
    .reset (reset),
    .bus   (w_bus.slave)
  );

  assign o_led = {w_bus.busy, w_bus.done, w_bus.y};

endmodule

// File: rtl/rotate_left_seq.sv
// Rotates a word left by amt positions, one bit position per clock, then
// pulses done for one cycle; the result stays in y until the next request.
module rotate_left_seq
  import rotate_left_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  rotate_left_seq_if.slave   bus
);

  state_t           r_state;
  logic [W-1:0]     r_y;
  logic [AMT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     w_rot;

  // One-position left rotate of the working register; MSB wraps to bit 0.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rot
      if (gi == 0) begin : g_wrap
        assign w_rot[gi] = r_y[W-1];
      end else begin : g_pass
        assign w_rot[gi] = r_y[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_y    <= bus.a;
            r_cnt  <= bus.amt;
            r_busy <= 1'b1;
            if (bus.amt != '0) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_y   <= w_rot;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y    = r_y;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Directed bench for rotate_left_seq: reset, single rotates, latency,
// ignored starts, reset abort and an exhaustive right/left round trip.
module tb_rotate_left_seq;
  import rotate_left_seq_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rotate_left_seq_if #(.W(W_DEF), .AMT_W(AMT_W_DEF)) bus ();

  rotate_left_seq #(.W(W_DEF), .AMT_W(AMT_W_DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference right-rotate used to pre-scramble the round-trip inputs.
  function automatic logic [7:0] ror8(input logic [7:0] v, input logic [2:0] n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < int'(n); k++) r = {r[0], r[7:1]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to completion plus one idle cycle.
  task automatic run_op(input string tag, input logic [7:0] a_v, input logic [2:0] amt_v,
                        input logic [7:0] exp_y, input bit quiet);
    int lat;
    int bc;
    bus.a     = a_v;
    bus.amt   = amt_v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    bc  = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bc++;
      tick();
      lat++;
    end
    if (bus.busy) bc++;
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(amt_v) + 32'd1);
    check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(amt_v) + 32'd1);
    check_eq({tag, "_y"}, 32'(bus.y), 32'(exp_y));
    tick();
    check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_y_hold"}, 32'(bus.y), 32'(exp_y));
    if (!quiet)
      $display("op %s a=%02h amt=%0d y=%02h latency=%0d", tag, a_v, amt_v, bus.y, lat);
  endtask

  initial begin
    int n_done;
    int seen_done;
    int guard;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.amt   = '0;

    // Reset held for two cycles.
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_y", 32'(bus.y), 32'h00);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    $display("op reset y=%02h busy=%0d done=%0d", bus.y, bus.busy, bus.done);

    run_op("single", 8'b1000_0001, 3'd3, 8'b0000_1100, 1'b0);

    // Inputs change with start low: result must hold.
    bus.a   = 8'hFF;
    bus.amt = 3'd2;
    tick();
    tick();
    tick();
    check_eq("hold_y", 32'(bus.y), 32'h0C);
    check_eq("hold_busy", 32'(bus.busy), 32'd0);
    $display("op hold y=%02h", bus.y);

    run_op("zero_amt", 8'hA5, 3'd0, 8'hA5, 1'b0);
    run_op("max_amt", 8'hB4, 3'd7, 8'h5A, 1'b0);
    run_op("back2back", 8'h3C, 3'd2, 8'hF0, 1'b0);

    // Starts during SHIFT and during DONE are ignored.
    bus.a     = 8'h01;
    bus.amt   = 3'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.a     = 8'hFF;
    bus.amt   = 3'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_done = 0;
    guard  = 0;
    while (!bus.done && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("ign_done_seen", 32'(bus.done), 32'd1);
    if (bus.done) n_done++;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("ign_not_accepted", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (bus.done) n_done++;
      tick();
    end
    check_eq("ign_one_done", 32'(n_done), 32'd1);
    check_eq("ign_y", 32'(bus.y), 32'h80);
    $display("op ignored_start y=%02h dones=%0d", bus.y, n_done);

    // Reset during the second SHIFT cycle aborts the operation.
    bus.a     = 8'h0F;
    bus.amt   = 3'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_eq("abort_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) seen_done = 1;
      tick();
    end
    check_eq("abort_no_done", 32'(seen_done), 32'd0);
    check_eq("abort_y", 32'(bus.y), 32'h00);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    $display("op reset_abort y=%02h done_seen=%0d", bus.y, seen_done);
    run_op("after_abort", 8'h0F, 3'd1, 8'h1E, 1'b0);

    // Round trip through a right rotate must restore the original word.
    for (int am = 0; am < 8; am++) begin
      int fails_before;
      fails_before = n_fail;
      for (int av = 0; av < 256; av++) begin
        run_op("roundtrip", ror8(8'(av), 3'(am)), 3'(am), 8'(av), 1'b1);
      end
      $display("op roundtrip amt=%0d words=256 new_failures=%0d", am, n_fail - fails_before);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
